// File: rtl/fir_interp_polyphase_pkg.sv
// Shared types, default prototype filter and saturation helper for the interpolating FIR.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_interp_polyphase_pkg;

    localparam int DEFAULT_INTERP = 4;
    localparam int DEFAULT_TAPS   = 4;
    localparam int DEFAULT_N      = DEFAULT_INTERP * DEFAULT_TAPS;

    // Symmetric low-pass prototype h[0..15]; the taps of every polyphase branch
    // (h[p], h[p+4], h[p+8], h[p+12]) sum to 32768, so DC gain per branch is 1.0
    // and the overall interpolator gain is L.
    localparam int DEFAULT_COEFFS [DEFAULT_N] = '{
        -200,  -500,  -800,  -600,
        1500, 10000, 24068, 32068,
        32068, 24068, 10000,  1500,
        -600,  -800,  -500,  -200
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'h7FFF;
        end else if (v < -64'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/fir_interp_polyphase_if.sv
// AXI-Stream beat bundle: data, strobe, valid, last and ready.
// Latency: none (wires only).
// Backpressure: tready flows from slave to master against the beat direction.
interface fir_interp_polyphase_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/fir_interp_polyphase_mac.sv
// Complex T-tap dot product of the delay line against one polyphase branch, rounded and saturated.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module fir_interp_polyphase_mac
    import fir_interp_polyphase_pkg::*;
#(
    parameter int INTERP         = 4,
    parameter int TAPS_PER_PHASE = 4,
    parameter int COEFF_WIDTH    = 18,
    parameter int SHIFT          = 15,
    parameter int COEFFS [INTERP*TAPS_PER_PHASE] = DEFAULT_COEFFS
) (
    input  logic [TAPS_PER_PHASE-1:0][31:0] x_dat,
    input  logic [$clog2(INTERP)-1:0]       phase,
    output logic [31:0]                     y_dat
);

    localparam int PW     = $clog2(INTERP);
    localparam int PROD_W = 16 + COEFF_WIDTH;
    localparam int ACC_W  = 16 + COEFF_WIDTH + $clog2(TAPS_PER_PHASE) + 1;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (SHIFT - 1));

    logic signed [COEFF_WIDTH-1:0] coef;
    logic signed [15:0]            xi;
    logic signed [15:0]            xq;
    logic signed [PROD_W-1:0]      prod_i;
    logic signed [PROD_W-1:0]      prod_q;
    logic signed [ACC_W-1:0]       acc_i;
    logic signed [ACC_W-1:0]       acc_q;
    logic signed [ACC_W-1:0]       rnd_i;
    logic signed [ACC_W-1:0]       rnd_q;
    logic signed [ACC_W-1:0]       sh_i;
    logic signed [ACC_W-1:0]       sh_q;

    // Accumulate x[k]*h[k*L+phase] over all taps, I and Q independently.
    always_comb begin
        coef   = '0;
        xi     = '0;
        xq     = '0;
        prod_i = '0;
        prod_q = '0;
        acc_i  = '0;
        acc_q  = '0;
        for (int k = 0; k < TAPS_PER_PHASE; k++) begin
            coef = '0;
            for (int q = 0; q < INTERP; q++) begin
                if (phase == PW'(q)) begin
                    coef = COEFF_WIDTH'(COEFFS[k*INTERP + q]);
                end
            end
            xi     = x_dat[k][31:16];
            xq     = x_dat[k][15:0];
            prod_i = xi * coef;
            prod_q = xq * coef;
            acc_i  = acc_i + ACC_W'(prod_i);
            acc_q  = acc_q + ACC_W'(prod_q);
        end
    end

    // Round half-up, arithmetic shift back to Q0, then clamp to 16 bits.
    assign rnd_i = acc_i + RND;
    assign rnd_q = acc_q + RND;
    assign sh_i  = rnd_i >>> SHIFT;
    assign sh_q  = rnd_q >>> SHIFT;
    assign y_dat = {sat16(64'(sh_i)), sat16(64'(sh_q))};

endmodule

// File: rtl/fir_interp_polyphase.sv
// Polyphase interpolating FIR: each accepted {I,Q} beat yields INTERP filtered output beats.
// Latency: first output beat is valid the cycle after the input handshake; then one beat per cycle.
// Backpressure: output held stable while tready is low; input accepted only in IDLE or alongside the final phase handshake.
module fir_interp_polyphase
    import fir_interp_polyphase_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int INTERP                 = 4,
    parameter int TAPS_PER_PHASE         = 4,
    parameter int COEFF_WIDTH            = 18,
    parameter int SHIFT                  = 15,
    parameter int COEFFS [INTERP*TAPS_PER_PHASE] = DEFAULT_COEFFS
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_aresetn,
    fir_interp_polyphase_if.slave         s00_axis,
    fir_interp_polyphase_if.master        m00_axis
);

    localparam int PW = $clog2(INTERP);
    localparam logic [PW-1:0] LAST_PHASE = PW'(INTERP - 1);

    state_t                                          state_q;
    state_t                                          state_d;
    logic [PW-1:0]                                   phase_q;
    logic [PW-1:0]                                   phase_d;
    logic [TAPS_PER_PHASE-1:0][C_S00_AXIS_TDATA_WIDTH-1:0] x_q;
    logic [TAPS_PER_PHASE-1:0][C_S00_AXIS_TDATA_WIDTH-1:0] x_d;
    logic [TAPS_PER_PHASE-1:0][C_S00_AXIS_TDATA_WIDTH-1:0] x_base;
    logic                                            tlast_q;
    logic                                            tlast_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]               tdata_q;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]               mac_dat;
    logic                                            load;
    logic                                            at_last;
    logic                                            in_hs;
    logic                                            out_hs;
    logic                                            unused_tstrb;

    assign unused_tstrb = ^s00_axis.tstrb;

    assign at_last         = (state_q == EMIT) && (phase_q == LAST_PHASE);
    assign s00_axis.tready = (state_q == IDLE) || (at_last && m00_axis.tready);
    assign in_hs           = s00_axis.tvalid && s00_axis.tready;
    assign out_hs          = (state_q == EMIT) && m00_axis.tready;

    // Next-state logic: accept a beat (restart at phase 0), advance the phase, or fall back to IDLE.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        x_d     = x_q;
        tlast_d = tlast_q;
        load    = 1'b0;
        // A framed beat's last output wipes history so the next frame starts clean.
        x_base  = (at_last && out_hs && tlast_q) ? '0 : x_q;
        if (in_hs) begin
            for (int k = TAPS_PER_PHASE - 1; k > 0; k--) begin
                x_d[k] = x_base[k-1];
            end
            x_d[0]  = s00_axis.tdata;
            phase_d = '0;
            tlast_d = s00_axis.tlast;
            state_d = EMIT;
            load    = 1'b1;
        end else if (out_hs) begin
            if (at_last) begin
                state_d = IDLE;
                x_d     = x_base;
                tlast_d = 1'b0;
            end else begin
                phase_d = phase_q + 1'b1;
                load    = 1'b1;
            end
        end
    end

    // The MAC sees the next delay line and phase so the result lands in the output register with no bubble.
    fir_interp_polyphase_mac #(
        .INTERP         (INTERP),
        .TAPS_PER_PHASE (TAPS_PER_PHASE),
        .COEFF_WIDTH    (COEFF_WIDTH),
        .SHIFT          (SHIFT),
        .COEFFS         (COEFFS)
    ) u_mac (
        .x_dat (x_d),
        .phase (phase_d),
        .y_dat (mac_dat)
    );

    // State, phase, delay line, frame flag and output register.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q <= IDLE;
            phase_q <= '0;
            x_q     <= '0;
            tlast_q <= 1'b0;
            tdata_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            tlast_q <= tlast_d;
            if (load) begin
                tdata_q <= mac_dat;
            end
        end
    end

    assign m00_axis.tdata  = tdata_q;
    assign m00_axis.tstrb  = '1;
    assign m00_axis.tvalid = (state_q == EMIT);
    assign m00_axis.tlast  = at_last && tlast_q;

endmodule

// File: tb/tb_fir_interp_polyphase.sv
// Self-checking bench: random and directed streams against a zero-stuff-and-convolve reference model.
// Latency: n/a.
// Backpressure: exercised with random and directed downstream stalls.
module tb_fir_interp_polyphase;

    localparam int L = 4;
    localparam int T = 4;
    localparam int N = L * T;
    localparam int SAT_COEFFS [N] = '{default: 32767};

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic aclk;
    logic aresetn;

    fir_interp_polyphase_if #(.DW(32)) s_if ();
    fir_interp_polyphase_if #(.DW(32)) m_if ();
    fir_interp_polyphase_if #(.DW(32)) s_sat ();
    fir_interp_polyphase_if #(.DW(32)) m_sat ();

    assign s_sat.tdata  = s_if.tdata;
    assign s_sat.tstrb  = s_if.tstrb;
    assign s_sat.tvalid = s_if.tvalid;
    assign s_sat.tlast  = s_if.tlast;
    assign m_sat.tready = m_if.tready;

    fir_interp_polyphase dut (
        .s00_axis_aclk    (aclk),
        .s00_axis_aresetn (aresetn),
        .s00_axis         (s_if),
        .m00_axis         (m_if)
    );

    fir_interp_polyphase #(.COEFFS(SAT_COEFFS)) dut_sat (
        .s00_axis_aclk    (aclk),
        .s00_axis_aresetn (aresetn),
        .s00_axis         (s_sat),
        .m00_axis         (m_sat)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int h_def [N] = '{-200, -500, -800, -600, 1500, 10000, 24068, 32068,
                      32068, 24068, 10000, 1500, -600, -800, -500, -200};

    beat_t       in_q[$];
    logic [31:0] got_dat[$];
    logic [31:0] got_sat[$];
    logic        got_last[$];
    logic [31:0] exp_dat[$];
    logic        exp_last[$];
    int          acc_cyc[$];
    int          out_cyc[$];
    logic [31:0] stall_dat[$];
    logic        stall_vld[$];
    logic        stall_srdy[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference: zero-stuff each frame by L, convolve with the N-tap prototype, round, clamp.
    function automatic void build_expected(input bit use_sat);
        int fs;
        int m;
        int i;
        int hj;
        longint ai;
        longint aq;
        longint ri;
        longint rq;
        exp_dat.delete();
        exp_last.delete();
        fs = 0;
        for (int n = 0; n < in_q.size(); n++) begin
            for (int p = 0; p < L; p++) begin
                m  = (n - fs) * L + p;
                ai = 0;
                aq = 0;
                for (int j = 0; j < N; j++) begin
                    i = m - j;
                    if (i >= 0 && (i % L) == 0) begin
                        hj = use_sat ? 32767 : h_def[j];
                        ai += longint'(hj) * longint'($signed(in_q[fs + i / L].d[31:16]));
                        aq += longint'(hj) * longint'($signed(in_q[fs + i / L].d[15:0]));
                    end
                end
                ri = (ai + 16384) >>> 15;
                rq = (aq + 16384) >>> 15;
                if (ri > 32767) ri = 32767;
                if (ri < -32768) ri = -32768;
                if (rq > 32767) rq = 32767;
                if (rq < -32768) rq = -32768;
                exp_dat.push_back({ri[15:0], rq[15:0]});
                exp_last.push_back(in_q[n].last && (p == L - 1));
            end
            if (in_q[n].last) fs = n + 1;
        end
    endfunction

    // Stimulus driver/collector. mode 0: always ready; 1: random valid/ready; 2: 5-cycle stall at 3rd output.
    task automatic run_beats(input int mode, input int n_stop, output bit timeout);
        int idx;
        int cyc;
        int stall_left;
        bit stalled;
        bit took;
        idx = 0; cyc = 0; stall_left = 0; stalled = 0; took = 1; timeout = 0;
        got_dat.delete(); got_sat.delete(); got_last.delete();
        acc_cyc.delete(); out_cyc.delete();
        stall_dat.delete(); stall_vld.delete(); stall_srdy.delete();
        while (got_dat.size() < n_stop) begin
            if (cyc > 2000) begin
                timeout = 1;
                break;
            end
            @(posedge aclk); #1;
            if (idx >= in_q.size()) begin
                s_if.tvalid = 1'b0;
            end else if (took || !s_if.tvalid) begin
                s_if.tvalid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (s_if.tvalid) begin
                s_if.tdata = in_q[idx].d;
                s_if.tlast = in_q[idx].last;
            end
            if (mode == 1) m_if.tready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) m_if.tready = (stall_left == 0);
            else m_if.tready = 1'b1;
            @(negedge aclk);
            took = 0;
            if (m_if.tvalid && m_if.tready) begin
                got_dat.push_back(m_if.tdata);
                got_last.push_back(m_if.tlast);
                got_sat.push_back(m_sat.tdata);
                out_cyc.push_back(cyc);
            end
            if (s_if.tvalid && s_if.tready) begin
                idx++;
                took = 1;
                acc_cyc.push_back(cyc);
            end
            if (mode == 2) begin
                if (stall_left > 0) begin
                    stall_dat.push_back(m_if.tdata);
                    stall_vld.push_back(m_if.tvalid);
                    stall_srdy.push_back(s_if.tready);
                    stall_left--;
                end else if (!stalled && got_dat.size() == 2) begin
                    stalled = 1;
                    stall_left = 5;
                end
            end
            cyc++;
        end
        @(posedge aclk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
        n_vec++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", m_if.tlast); end
        n_vec++; if (m_if.tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata got %h want 0", m_if.tdata); end
        n_vec++; if (m_if.tstrb !== 4'hF) begin n_err++; $display("FAIL reset_tstrb got %h want f", m_if.tstrb); end
        n_vec++; if (s_if.tready !== 1'b1) begin n_err++; $display("FAIL reset_s_tready got %b want 1", s_if.tready); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    task automatic test_impulse();
        bit to;
        logic [15:0] hi;
        in_q.delete();
        in_q.push_back('{d: 32'h4000_0000, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b1});
        build_expected(0);
        run_beats(0, N, to);
        n_vec++; if (to) begin n_err++; $display("FAIL impulse_timeout got %0d beats want %0d", got_dat.size(), N); end
        for (int j = 0; j < got_dat.size() && j < N; j++) begin
            hi = 16'(h_def[j] / 2);
            n_vec++; if (got_dat[j] !== exp_dat[j]) begin n_err++; $display("FAIL impulse_model[%0d] got %h want %h", j, got_dat[j], exp_dat[j]); end
            n_vec++; if (got_dat[j] !== {hi, 16'h0}) begin n_err++; $display("FAIL impulse_h[%0d] got %h want %h", j, got_dat[j], {hi, 16'h0}); end
            n_vec++; if (got_last[j] !== (j == N - 1)) begin n_err++; $display("FAIL impulse_tlast[%0d] got %b want %b", j, got_last[j], (j == N - 1)); end
        end
    endtask

    task automatic test_throughput();
        bit to;
        in_q.delete();
        for (int n = 0; n < 12; n++) in_q.push_back('{d: $urandom, last: (n == 11)});
        build_expected(0);
        run_beats(0, 48, to);
        n_vec++; if (to || acc_cyc.size() != 12) begin n_err++; $display("FAIL thru_count got %0d outs %0d ins want 48 12", got_dat.size(), acc_cyc.size()); end
        if (!to && acc_cyc.size() == 12) begin
            n_vec++; if (out_cyc[47] - out_cyc[0] != 47) begin n_err++; $display("FAIL thru_no_bubble got span %0d want 47", out_cyc[47] - out_cyc[0]); end
            for (int i = 1; i < 12; i++) begin
                n_vec++; if (acc_cyc[i] - acc_cyc[i-1] != L) begin n_err++; $display("FAIL thru_in_gap[%0d] got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], L); end
            end
            for (int j = 0; j < 48; j++) begin
                n_vec++; if (got_dat[j] !== exp_dat[j] || got_last[j] !== exp_last[j]) begin n_err++; $display("FAIL thru_data[%0d] got %h/%b want %h/%b", j, got_dat[j], got_last[j], exp_dat[j], exp_last[j]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        in_q.delete();
        in_q.push_back('{d: $urandom, last: 1'b0});
        in_q.push_back('{d: $urandom, last: 1'b1});
        build_expected(0);
        run_beats(2, 8, to);
        n_vec++; if (to || stall_dat.size() != 5) begin n_err++; $display("FAIL bp_count got %0d outs %0d stalls want 8 5", got_dat.size(), stall_dat.size()); end
        for (int c = 0; c < stall_dat.size(); c++) begin
            n_vec++; if (stall_vld[c] !== 1'b1) begin n_err++; $display("FAIL bp_tvalid[%0d] got %b want 1", c, stall_vld[c]); end
            n_vec++; if (stall_srdy[c] !== 1'b0) begin n_err++; $display("FAIL bp_s_tready[%0d] got %b want 0", c, stall_srdy[c]); end
            n_vec++; if (stall_dat[c] !== exp_dat[2]) begin n_err++; $display("FAIL bp_tdata[%0d] got %h want %h", c, stall_dat[c], exp_dat[2]); end
        end
        for (int j = 0; j < got_dat.size() && j < 8; j++) begin
            n_vec++; if (got_dat[j] !== exp_dat[j] || got_last[j] !== exp_last[j]) begin n_err++; $display("FAIL bp_data[%0d] got %h/%b want %h/%b", j, got_dat[j], got_last[j], exp_dat[j], exp_last[j]); end
        end
    endtask

    task automatic test_framing();
        bit to;
        logic [15:0] hi;
        in_q.delete();
        for (int n = 0; n < 3; n++) in_q.push_back('{d: $urandom, last: (n == 2)});
        in_q.push_back('{d: 32'h4000_0000, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b1});
        build_expected(0);
        run_beats(0, 28, to);
        n_vec++; if (to) begin n_err++; $display("FAIL frame_timeout got %0d beats want 28", got_dat.size()); end
        for (int j = 0; j < got_dat.size() && j < 28; j++) begin
            n_vec++; if (got_last[j] !== (j == 11 || j == 27)) begin n_err++; $display("FAIL frame_tlast[%0d] got %b want %b", j, got_last[j], (j == 11 || j == 27)); end
            n_vec++; if (got_dat[j] !== exp_dat[j]) begin n_err++; $display("FAIL frame_data[%0d] got %h want %h", j, got_dat[j], exp_dat[j]); end
            if (j >= 12) begin
                hi = 16'(h_def[j-12] / 2);
                n_vec++; if (got_dat[j] !== {hi, 16'h0}) begin n_err++; $display("FAIL frame_residue[%0d] got %h want %h", j, got_dat[j], {hi, 16'h0}); end
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int len;
        logic [31:0] d;
        in_q.delete();
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 5);
            for (int n = 0; n < len; n++) begin
                d = $urandom;
                if ($urandom_range(0, 3) == 0) d = {d[31] ? 16'h8000 : 16'h7FFF, d[15] ? 16'h7FFF : 16'h8000};
                in_q.push_back('{d: d, last: (n == len - 1)});
            end
        end
        build_expected(0);
        run_beats(1, exp_dat.size(), to);
        n_vec++; if (to) begin n_err++; $display("FAIL rand_timeout got %0d beats want %0d", got_dat.size(), exp_dat.size()); end
        for (int j = 0; j < got_dat.size() && j < exp_dat.size(); j++) begin
            n_vec++; if (got_dat[j] !== exp_dat[j] || got_last[j] !== exp_last[j]) begin n_err++; $display("FAIL rand_data[%0d] got %h/%b want %h/%b", j, got_dat[j], got_last[j], exp_dat[j], exp_last[j]); end
        end
    endtask

    task automatic test_saturation();
        bit to;
        in_q.delete();
        for (int n = 0; n < T; n++) in_q.push_back('{d: 32'h7FFF_8000, last: (n == T - 1)});
        build_expected(1);
        run_beats(0, N, to);
        n_vec++; if (to) begin n_err++; $display("FAIL sat_timeout got %0d beats want %0d", got_sat.size(), N); end
        for (int j = 0; j < got_sat.size() && j < N; j++) begin
            n_vec++; if (got_sat[j] !== exp_dat[j]) begin n_err++; $display("FAIL sat_model[%0d] got %h want %h", j, got_sat[j], exp_dat[j]); end
            if (j >= N - L) begin
                n_vec++; if (got_sat[j] !== 32'h7FFF_8000) begin n_err++; $display("FAIL sat_clamp[%0d] got %h want 7fff8000", j, got_sat[j]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        logic [15:0] hi;
        in_q.delete();
        in_q.push_back('{d: $urandom | 32'h4000_4000, last: 1'b0});
        in_q.push_back('{d: $urandom | 32'h4000_4000, last: 1'b0});
        run_beats(0, L + 1, to);
        n_vec++; if (to) begin n_err++; $display("FAIL rstmid_timeout got %0d beats want %0d", got_dat.size(), L + 1); end
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", m_if.tvalid); end
        n_vec++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL rstmid_tlast got %b want 0", m_if.tlast); end
        n_vec++; if (m_if.tdata !== 32'h0) begin n_err++; $display("FAIL rstmid_tdata got %h want 0", m_if.tdata); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        in_q.delete();
        in_q.push_back('{d: 32'h4000_0000, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b0});
        in_q.push_back('{d: 32'h0, last: 1'b1});
        run_beats(0, N, to);
        n_vec++; if (to) begin n_err++; $display("FAIL rstmid_imp_timeout got %0d beats want %0d", got_dat.size(), N); end
        for (int j = 0; j < got_dat.size() && j < N; j++) begin
            hi = 16'(h_def[j] / 2);
            n_vec++; if (got_dat[j] !== {hi, 16'h0}) begin n_err++; $display("FAIL rstmid_h[%0d] got %h want %h", j, got_dat[j], {hi, 16'h0}); end
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tstrb  = 4'hF;
        m_if.tready = 1'b1;
        aresetn     = 1'b0;
        test_reset();
        test_impulse();
        test_throughput();
        test_backpressure();
        test_framing();
        test_random();
        test_saturation();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
